router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, consecutive unread cycles before a FIFO soft reset.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pkt_valid  input  1  source framing; 1 on header/payload bytes, 0 on the final parity byte.
REQ-005 SHALL have port data_in  input  8  source byte; header = {payload_len[5:0], addr[1:0]}.
REQ-006 SHALL have ports fifo_full / fifo_empty  input  3 each  status of FIFOs 0..2.
REQ-007 SHALL have port read_enb  input  3  per-FIFO read strobes from the output side.
REQ-008 SHALL have port write_enb  output  3  one-hot FIFO write strobe (at most one bit set).
REQ-009 SHALL have port lfd_state  output  1  marks header write, to FIFO lfd_state.
REQ-010 SHALL have port busy  output  1  source must hold data_in and pkt_valid while 1.
REQ-011 SHALL have ports valid_out / soft_reset  output  3 each  per-FIFO data-available and one-cycle soft-reset pulse.
REQ-012 SHALL have port err  output  1  one-cycle parity-mismatch pulse.

Function
REQ-013 FSM states SHALL be DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET.
REQ-014 DECODE_ADDRESS, pkt_valid=1: latch addr=data_in[1:0]; addr=3 -> DROP_PACKET; fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY; pkt_valid=0 -> stay.
REQ-015 WAIT_TILL_EMPTY: busy=1, no writes; -> LOAD_FIRST_DATA when fifo_empty[addr]=1.
REQ-016 LOAD_FIRST_DATA: write_enb[addr]=1, lfd_state=1, busy=1, parity accumulator := data_in; -> LOAD_DATA.
REQ-017 LOAD_DATA, fifo_full[addr]=0: write_enb[addr]=1, busy=0, accumulator ^= data_in only when pkt_valid=1, held parity byte := data_in when pkt_valid=0; pkt_valid=0 -> CHECK_PARITY_ERROR, else stay.
REQ-018 LOAD_DATA, fifo_full[addr]=1: no write, busy=1 in the same cycle (combinational); -> FIFO_FULL_STATE.
REQ-019 FIFO_FULL_STATE: busy=1, no write; -> LOAD_AFTER_FULL when fifo_full[addr]=0.
REQ-020 LOAD_AFTER_FULL: write held data_in, busy=1, apply REQ-017 accumulation; pkt_valid=0 -> CHECK_PARITY_ERROR, else -> LOAD_DATA.
REQ-021 CHECK_PARITY_ERROR: busy=1; err=1 for this one cycle iff accumulator != held parity byte; -> DECODE_ADDRESS.
REQ-022 DROP_PACKET: busy=0, no writes; -> DECODE_ADDRESS after a cycle with pkt_valid=0.
REQ-023 busy SHALL be 0 only in DECODE_ADDRESS, DROP_PACKET, and LOAD_DATA with fifo_full[addr]=0.
REQ-024 valid_out[i] SHALL equal ~fifo_empty[i] combinationally.
REQ-025 Per FIFO i, an 5-bit (clog2) counter SHALL increment each cycle valid_out[i]=1 and read_enb[i]=0, and clear when either is false.
REQ-026 soft_reset[i] SHALL pulse 1 cycle when the counter reaches TIMEOUT-1 and is incremented; counter clears in that cycle.
REQ-027 soft_reset[addr] while FSM is outside DECODE_ADDRESS/DROP_PACKET SHALL abort the packet: -> DECODE_ADDRESS next cycle, no err.
REQ-028 Simultaneous read_enb[i] and timeout edge SHALL suppress soft_reset[i].

Reset
REQ-029 reset=1 SHALL asynchronously force DECODE_ADDRESS, addr=0, accumulator=0, counters=0, write_enb=0, lfd_state=0, busy=0, err=0, soft_reset=0.
REQ-030 Reset mid-packet SHALL discard the packet; first cycle after release decodes a fresh header.

Structure
REQ-031 State encoding, header field positions, and ADDR_INVALID=2'd3 SHALL live in shared package router_pkg.
REQ-032 Timeout counter SHALL be a sub-module router_timeout, instantiated three times.

Verification
REQ-033 Header 8'h39 (len 14, addr 1), FIFO1 empty, 14 payload, parity correct -> write_enb=3'b010 for 16 cycles, lfd_state only on first, err=0.
REQ-034 Same packet, parity byte XOR 8'h01 -> err=1 exactly one cycle in CHECK_PARITY_ERROR.
REQ-035 fifo_full[1] raised at payload 5 for 3 cycles -> busy=1 same cycle, no write until release, byte 5 written once in LOAD_AFTER_FULL.
REQ-036 Header addr 2, fifo_empty[2]=0 -> busy=1, WAIT_TILL_EMPTY until fifo_empty[2]=1, then header written.
REQ-037 fifo_empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0] pulse on cycle 30; read_enb[0]=1 on cycle 29 -> no pulse.
REQ-038 Header 8'h03 (addr 3) -> no write_enb for the whole packet, busy=0, back to DECODE_ADDRESS after parity byte.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the packet router controller: FSM state encoding,
// header field positions and the reserved "no such FIFO" address.
// No ports; imported by router_ctrl.
package router_pkg;

    localparam int NUM_FIFOS    = 3;

    // Header byte layout: {payload_len[5:0], addr[1:0]}
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // Address 3 has no FIFO behind it; such packets are swallowed
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_e;

    function automatic logic [1:0] hdrAddr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

    function automatic logic [5:0] hdrLen(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_timeout.sv
// router_timeout
// Watches one output FIFO. While the FIFO holds data and nobody reads it,
// a counter runs; after TIMEOUT such consecutive cycles a one-cycle soft
// reset pulse is issued so stale data cannot block the router forever.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   valid_i       - FIFO has data (valid_out of that FIFO)
//   read_i        - output side is reading the FIFO this cycle
//   softReset_o   - one-cycle pulse on the TIMEOUT-th unread cycle
module router_timeout #(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic valid_i,
    input  logic read_i,
    output logic softReset_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          idle;

    // A read in the same cycle as the would-be timeout wins: idle drops,
    // so the pulse is suppressed and the count restarts.
    assign idle = valid_i && !read_i;

    // The pulse is raised in the cycle the count sits at TIMEOUT-1 and
    // would increment again; the counter wraps to zero on that same edge.
    always_comb begin
        count_d     = '0;
        softReset_o = 1'b0;
        if (idle) begin
            if (count_q == LAST) begin
                softReset_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// router_ctrl
// Control FSM of a 1-to-3 packet router. Decodes the header address, steers
// bytes into one of three FIFOs via a one-hot write strobe, throttles the
// source with busy while the target FIFO is full or not yet drained, checks
// the trailing parity byte, and soft-resets FIFOs whose data goes unread.
// Ports:
//   clock, reset           - clock and asynchronous active-high reset
//   pkt_valid, data_in     - source byte stream (pkt_valid=0 on parity byte)
//   fifo_full, fifo_empty  - per-FIFO status
//   read_enb               - per-FIFO read strobes from the output side
//   write_enb, lfd_state   - FIFO write strobe and header marker
//   busy                   - source must hold its byte while high
//   valid_out, soft_reset  - per-FIFO data available / timeout pulse
//   err                    - one-cycle parity mismatch pulse
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_FIFOS-1:0] fifo_full,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] read_enb,
    output logic [NUM_FIFOS-1:0] write_enb,
    output logic                 lfd_state,
    output logic                 busy,
    output logic [NUM_FIFOS-1:0] valid_out,
    output logic [NUM_FIFOS-1:0] soft_reset,
    output logic                 err
);

    state_e     state_q;
    logic [1:0] addr_q;
    logic [7:0] parityAcc_q;
    logic [7:0] parityByte_q;

    logic [3:0] fullPad;
    logic [3:0] emptyPad;
    logic [3:0] softPad;
    logic [1:0] addrIn;
    logic       addrFull;
    logic       addrEmpty;
    logic       abort;
    logic       writeNow;

    assign valid_out = ~fifo_empty;

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : gTimeout
        router_timeout #(
            .TIMEOUT (TIMEOUT)
        ) uTimeout (
            .clock       (clock),
            .reset       (reset),
            .valid_i     (valid_out[i]),
            .read_i      (read_enb[i]),
            .softReset_o (soft_reset[i])
        );
    end

    // Status vectors are padded to four entries so the 2-bit address can
    // index them directly; the padding entry (address 3) is never consulted
    // outside DROP_PACKET.
    assign fullPad   = {1'b0, fifo_full};
    assign emptyPad  = {1'b1, fifo_empty};
    assign softPad   = {1'b0, soft_reset};
    assign addrIn    = hdrAddr(data_in);
    assign addrFull  = fullPad[addr_q];
    assign addrEmpty = emptyPad[addr_q];

    // A timeout on the FIFO we are feeding kills the packet in flight.
    assign abort = softPad[addr_q] &&
                   (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET);

    // Output decode. busy in LOAD_DATA follows fifo_full combinationally so
    // the source freezes in the very cycle the FIFO fills.
    always_comb begin
        writeNow  = 1'b0;
        lfd_state = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     busy = 1'b0;
            WAIT_TILL_EMPTY:    busy = 1'b1;
            LOAD_FIRST_DATA: begin
                writeNow  = 1'b1;
                lfd_state = 1'b1;
            end
            LOAD_DATA: begin
                writeNow = !addrFull;
                busy     = addrFull;
            end
            FIFO_FULL_STATE:    busy = 1'b1;
            LOAD_AFTER_FULL:    writeNow = 1'b1;
            CHECK_PARITY_ERROR: err = (parityAcc_q != parityByte_q) && !abort;
            DROP_PACKET:        busy = 1'b0;
            default:            busy = 1'b0;
        endcase
        if (abort) begin
            writeNow  = 1'b0;
            lfd_state = 1'b0;
        end
    end

    // Steer the single write strobe to the latched address
    always_comb begin
        write_enb = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            write_enb[i] = writeNow && (addr_q == 2'(i));
        end
    end

    // FSM with address latch and parity datapath. The header seeds the
    // accumulator; payload bytes fold in; the pkt_valid=0 byte is kept
    // aside for comparison in CHECK_PARITY_ERROR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= DECODE_ADDRESS;
            addr_q       <= '0;
            parityAcc_q  <= '0;
            parityByte_q <= '0;
        end else if (abort) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        addr_q <= addrIn;
                        if (addrIn == ADDR_INVALID) begin
                            state_q <= DROP_PACKET;
                        end else if (emptyPad[addrIn]) begin
                            state_q <= LOAD_FIRST_DATA;
                        end else begin
                            state_q <= WAIT_TILL_EMPTY;
                        end
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (addrEmpty) begin
                        state_q <= LOAD_FIRST_DATA;
                    end
                end
                LOAD_FIRST_DATA: begin
                    parityAcc_q <= data_in;
                    state_q     <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (addrFull) begin
                        state_q <= FIFO_FULL_STATE;
                    end else if (pkt_valid) begin
                        parityAcc_q <= parityAcc_q ^ data_in;
                    end else begin
                        parityByte_q <= data_in;
                        state_q      <= CHECK_PARITY_ERROR;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!addrFull) begin
                        state_q <= LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (pkt_valid) begin
                        parityAcc_q <= parityAcc_q ^ data_in;
                        state_q     <= LOAD_DATA;
                    end else begin
                        parityByte_q <= data_in;
                        state_q      <= CHECK_PARITY_ERROR;
                    end
                end
                CHECK_PARITY_ERROR: state_q <= DECODE_ADDRESS;
                DROP_PACKET: begin
                    if (!pkt_valid) begin
                        state_q <= DECODE_ADDRESS;
                    end
                end
                default: state_q <= DECODE_ADDRESS;
            endcase
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl
// Self-checking bench for router_ctrl. Packets are built here, their
// expected FIFO writes are queued, and a negedge monitor pops and compares
// every write the DUT makes. Also covers stall/wait handshakes, dropped
// packets, timeout soft resets with abort, and reset in mid-packet.
module tb_router_ctrl;

    localparam logic [1:0] BAD_ADDR = 2'd3;

    typedef struct {
        logic [2:0] port;
        logic [7:0] data;
        logic       lfd;
    } wrExp_t;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic       busy;
    logic [2:0] valid_out;
    logic [2:0] soft_reset;
    logic       err;

    int checkCount = 0;
    int errorCount = 0;
    int errSeen    = 0;
    wrExp_t expQ[$];

    router_ctrl #(
        .TIMEOUT (30)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .busy       (busy),
        .valid_out  (valid_out),
        .soft_reset (soft_reset),
        .err        (err)
    );

    // 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Write scoreboard: every DUT write must match the oldest expected one
    always @(negedge clock) begin : monitor
        wrExp_t e;
        if (!reset) begin
            if (write_enb != 3'b000) begin
                checkOutput("wrOneHot", $countones(write_enb), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpWrite", {29'd0, write_enb}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wrPort", {29'd0, write_enb}, {29'd0, e.port});
                    checkOutput("wrData", {24'd0, data_in}, {24'd0, e.data});
                    checkOutput("wrLfd", {31'd0, lfd_state}, {31'd0, e.lfd});
                end
            end
            if (err) errSeen++;
        end
    end

    // Source model: drives one packet, advances a byte whenever the DUT
    // wrote it (or every cycle for a dropped packet). Optional fifo_full
    // stall at payload index fullAt, optional initial non-empty target FIFO.
    task automatic applyStimulus(input logic [1:0] a, input int len, input bit badParity,
                                 input int fullAt, input int emptyDelay);
        logic [7:0] stream[$];
        logic [7:0] par;
        logic [7:0] b;
        wrExp_t     e;
        int         idx;
        int         iter;
        int         fullLeft;
        int         emptyLeft;
        int         expErr;
        bit         wr;
        bit         fullStarted;
        bit         fullCheck;

        stream.push_back({6'(len), a});
        par = stream[0];
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            stream.push_back(b);
            par ^= b;
        end
        if (badParity) par ^= 8'h01;
        stream.push_back(par);

        expErr = 0;
        if (a != BAD_ADDR) begin
            for (int i = 0; i < stream.size(); i++) begin
                e.port = 3'b001 << a;
                e.data = stream[i];
                e.lfd  = (i == 0);
                expQ.push_back(e);
            end
            expErr = badParity ? 1 : 0;
        end

        errSeen     = 0;
        idx         = 0;
        iter        = 0;
        fullLeft    = 0;
        emptyLeft   = 0;
        fullStarted = 1'b0;
        fullCheck   = 1'b0;
        if (emptyDelay > 0) begin
            fifo_empty[a] = 1'b0;
            emptyLeft     = emptyDelay;
        end
        pkt_valid = 1'b1;
        data_in   = stream[0];

        while (idx < stream.size() && iter < 200) begin
            @(negedge clock);
            wr = (write_enb != 3'b000);
            if (a == BAD_ADDR) checkOutput("dropBusy", {31'd0, busy}, 0);
            if (fullCheck) begin
                checkOutput("fullBusy", {31'd0, busy}, 1);
                checkOutput("fullNoWr", {29'd0, write_enb}, 0);
                fullCheck = 1'b0;
            end
            if (emptyLeft > 0 && iter > 0) checkOutput("waitBusy", {31'd0, busy}, 1);
            @(posedge clock);
            #1;
            iter++;
            if (wr || a == BAD_ADDR) idx++;
            if (idx < stream.size()) begin
                data_in   = stream[idx];
                pkt_valid = (idx != stream.size() - 1);
            end else begin
                pkt_valid = 1'b0;
            end
            if (fullLeft > 0) begin
                fullLeft--;
                if (fullLeft == 0) fifo_full[a] = 1'b0;
            end else if (fullAt >= 0 && !fullStarted && idx == fullAt + 1) begin
                fifo_full[a] = 1'b1;
                fullLeft     = 3;
                fullStarted  = 1'b1;
                fullCheck    = 1'b1;
            end
            if (emptyLeft > 0) begin
                emptyLeft--;
                if (emptyLeft == 0) fifo_empty[a] = 1'b1;
            end
        end
        if (idx < stream.size()) checkOutput("pktStalled", idx, stream.size());

        idleCycles(2);
        checkOutput("errPulses", errSeen, expErr);
        checkOutput("sbEmpty", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin : mainSeq
        wrExp_t e;
        reset      = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;

        #2 reset = 1'b1;
        #1;
        checkOutput("rstWrite", {29'd0, write_enb}, 0);
        checkOutput("rstBusy", {31'd0, busy}, 0);
        checkOutput("rstLfd", {31'd0, lfd_state}, 0);
        checkOutput("rstErr", {31'd0, err}, 0);
        checkOutput("rstSoft", {29'd0, soft_reset}, 0);
        checkOutput("rstValid", {29'd0, valid_out}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] good packet 0x39 to FIFO1");
        applyStimulus(2'd1, 14, 1'b0, -1, 0);
        $display("[TB] bad parity packet to FIFO1");
        applyStimulus(2'd1, 14, 1'b1, -1, 0);
        $display("[TB] FIFO1 full at payload 5");
        applyStimulus(2'd1, 14, 1'b0, 5, 0);
        $display("[TB] FIFO2 not empty at header");
        applyStimulus(2'd2, 3, 1'b0, -1, 4);
        $display("[TB] dropped packets to address 3");
        applyStimulus(BAD_ADDR, 0, 1'b0, -1, 0);
        applyStimulus(BAD_ADDR, 5, 1'b0, -1, 0);
        applyStimulus(2'd0, 2, 1'b0, -1, 0);

        $display("[TB] timeout on FIFO0 aborting a waiting header");
        errSeen       = 0;
        fifo_empty[0] = 1'b0;
        pkt_valid     = 1'b1;
        data_in       = 8'h00;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clock);
            if (c == 1) checkOutput("validOut", {29'd0, valid_out}, 3'b001);
            if (c <= 30) checkOutput("softRst0", {31'd0, soft_reset[0]}, (c == 30) ? 1 : 0);
            if (c == 30) checkOutput("abortBusyPre", {31'd0, busy}, 1);
            if (c == 31) checkOutput("abortBusyPost", {31'd0, busy}, 0);
            @(posedge clock);
            #1;
            if (c == 30) pkt_valid = 1'b0;
        end
        fifo_empty[0] = 1'b1;
        idleCycles(2);
        checkOutput("abortNoErr", errSeen, 0);
        checkOutput("abortNoWr", expQ.size(), 0);

        $display("[TB] read on cycle 29 suppresses timeout");
        fifo_empty[0] = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            read_enb[0] = (c == 29);
            @(negedge clock);
            checkOutput("softRstRead", {31'd0, soft_reset[0]}, 0);
            @(posedge clock);
            #1;
        end
        read_enb   = 3'b000;
        fifo_empty = 3'b111;
        idleCycles(2);

        $display("[TB] reset in mid-packet");
        e.port = 3'b010;
        e.data = 8'h39;
        e.lfd  = 1'b1;
        expQ.push_back(e);
        pkt_valid = 1'b1;
        data_in   = 8'h39;
        @(posedge clock);
        #1;
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checkOutput("midRstWrite", {29'd0, write_enb}, 0);
        checkOutput("midRstBusy", {31'd0, busy}, 0);
        checkOutput("midRstLfd", {31'd0, lfd_state}, 0);
        checkOutput("midRstHdr", expQ.size(), 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        pkt_valid = 1'b0;
        @(negedge clock);
        checkOutput("postRstBusy", {31'd0, busy}, 0);
        checkOutput("postRstWrite", {29'd0, write_enb}, 0);
        @(posedge clock);
        #1;
        applyStimulus(2'd1, 2, 1'b0, -1, 0);

        $display("[TB] mixed packets");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k % 3), 1 + int'($urandom_range(0, 6)), (k == 2), -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Absolute bound on run time
    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
